parity_bit_gen: RTL and testbench

- Registered 4-bit parity-bit generator and checker.
- Takes a nibble on ina..ind (ina = MSB, ind = LSB) and produces parity bit outp one clock later.
- Default mode is even parity: outp = ina ^ inb ^ inc ^ ind, so the 5-bit word {nibble, outp} always has an even number of ones.
- Also checks a received parity bit against the computed one and counts mismatches; sits at the edge of a simple serial/nibble datapath.

---
 rtl/parity_bit_gen.sv | 91 +++++++++
 tb/tb_parity_bit_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/parity_bit_gen.sv
`default_nettype none
// ============================================================================
//  Module   : parity_bit_gen
//  Purpose  : Registered 4-bit parity generator and checker. Computes the
//             parity of the nibble {ina,inb,inc,ind} one cycle after it is
//             accepted, compares it with a received parity bit, and keeps a
//             saturating count of mismatches.
//  Revision : 1.0 - initial release
// ============================================================================
module parity_bit_gen #(
  parameter int ODD_DEFAULT = 0,  // 0 = even parity, 1 = odd, when odd_sel = 0
  parameter int CNT_W       = 8   // width of the saturating mismatch counter
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ina,
  input  logic             inb,
  input  logic             inc,
  input  logic             ind,
  input  logic             in_valid,
  input  logic             odd_sel,
  input  logic             chk_par,
  input  logic             clr_cnt,
  output logic             outp,
  output logic             out_valid,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  // Parity sense baked in at integration; odd_sel flips it at run time.
  localparam logic             C_ODD_DEF = (ODD_DEFAULT != 0);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             outp_q,      outp_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q,       err_d;
  logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;

  logic             par_calc;
  logic             mismatch;

  // Parity of the incoming nibble and its comparison with the received bit.
  always_comb begin
    par_calc = ina ^ inb ^ inc ^ ind ^ odd_sel ^ C_ODD_DEF;
    mismatch = (chk_par != par_calc);
  end

  // Next-state: outp holds while idle, err and out_valid only live for the
  // cycle after an accepted nibble, counter clears with priority and saturates.
  always_comb begin
    outp_d      = outp_q;
    out_valid_d = in_valid;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (in_valid) begin
      outp_d = par_calc;
      err_d  = mismatch;
    end

    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (in_valid && mismatch && (err_cnt_q != C_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + C_CNT_ONE;
    end
  end

  // State registers; reset wins over every other input and drops any
  // nibble being accepted on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outp_q      <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      outp_q      <= outp_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign outp      = outp_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_bit_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parity_bit_gen
//  Purpose  : Self-checking bench for parity_bit_gen (CNT_W = 2 so that
//             counter saturation is reachable quickly).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_parity_bit_gen;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ina, inb, inc, ind;
  logic             in_valid, odd_sel, chk_par, clr_cnt;
  logic             outp, out_valid, err;
  logic [CNT_W-1:0] err_cnt;

  parity_bit_gen #(.ODD_DEFAULT(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ina(ina), .inb(inb), .inc(inc), .ind(ind),
    .in_valid(in_valid), .odd_sel(odd_sel), .chk_par(chk_par),
    .clr_cnt(clr_cnt),
    .outp(outp), .out_valid(out_valid), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             outp;
    logic             valid;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  m;             // model state
  int    n_total = 0;
  int    n_bad   = 0;
  // Even parity of nibble 0..15, bit i = parity of i.
  logic [15:0] even_tab = 16'h6996;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_par(input logic [3:0] nib, input logic odd);
    logic [15:0] t;
    t = even_tab;
    return t[nib] ^ odd;
  endfunction

  // Drive one cycle of stimulus, push the model's expectation, then compare.
  task automatic step(input logic rn, input logic v, input logic [3:0] nib,
                      input logic odd, input logic chk, input logic clr);
    logic p;
    exp_t e;
    rst_n = rn; in_valid = v; {ina, inb, inc, ind} = nib;
    odd_sel = odd; chk_par = chk; clr_cnt = clr;
    p = exp_par(nib, odd);
    if (!rn) begin
      m = '0;
    end else begin
      m.valid = v;
      m.err   = v && (chk != p);
      if (v) m.outp = p;
      if (clr) m.cnt = '0;
      else if (v && (chk != p) && (m.cnt != {CNT_W{1'b1}})) m.cnt = m.cnt + 1'b1;
    end
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("outp",      {31'd0, outp},      {31'd0, e.outp});
    check("out_valid", {31'd0, out_valid}, {31'd0, e.valid});
    check("err",       {31'd0, err},       {31'd0, e.err});
    check("err_cnt",   {30'd0, err_cnt},   {30'd0, e.cnt});
  endtask

  initial begin
    logic [3:0] nib;
    m = '0;
    rst_n = 1'b0; in_valid = 1'b0; {ina, inb, inc, ind} = 4'h0;
    odd_sel = 1'b0; chk_par = 1'b0; clr_cnt = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    // Even sweep, then odd sweep, correct chk_par so no errors.
    for (int i = 0; i < 16; i++) begin
      nib = 4'(i);
      step(1'b1, 1'b1, nib, 1'b0, exp_par(nib, 1'b0), 1'b0);
      check("even_tab", {31'd0, outp}, {31'd0, even_tab[i]});
    end
    for (int i = 0; i < 16; i++) begin
      nib = 4'(i);
      step(1'b1, 1'b1, nib, 1'b1, exp_par(nib, 1'b1), 1'b0);
      check("odd_tab", {31'd0, outp}, {31'd0, ~even_tab[i]});
    end

    // Checker: 1011 under odd parity computes 0; chk_par=1 mismatches.
    step(1'b1, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0);
    check("chk_err1", {30'd0, err_cnt}, 32'd1);
    step(1'b1, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
    check("chk_err0", {30'd0, err_cnt}, 32'd1);

    // Saturation: five more mismatches, counter sticks at 3.
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("sat", {30'd0, err_cnt}, 32'd3);
    // Clear beats a simultaneous mismatch.
    step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
    check("clr_wins", {30'd0, err_cnt}, 32'd0);

    // Idle: outp holds (last nibble 0000 even -> 0; load 0001 first -> 1).
    step(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    check("idle_hold", {31'd0, outp}, 32'd1);

    // Reset mid-burst: nibble 0111 (parity 1) accepted under reset is lost.
    step(1'b1, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("rst_lost", {31'd0, outp}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 60; i++)
      step(1'b1, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 7) == 0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
